// File: rtl/mips_pkg.sv
// Shared types for the core-side memory path: big-endian byte-lane word and
// the data cache controller states.
package mips_pkg;

  // Lane [0] is the most significant byte of the word.
  typedef logic [0:3][7:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/data_cache_if.sv
// Backing-memory bus between the data cache (master) and memory (slave).
interface data_cache_if;
  import mips_pkg::*;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  word_t       mem_wdata;
  word_t       mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cache_tag_ram.sv
// Valid/tag/data line store: one synchronous write port, one asynchronous read
// port. Only the valid bits are reset; tags and data hold whatever was there.
module cache_tag_ram
  import mips_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_valid,
  output logic [29-IDX_W:0]   rd_tag,
  output word_t               rd_data,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [29-IDX_W:0]   wr_tag,
  input  word_t               wr_data
);

  localparam int TAG_W = 30 - IDX_W;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  word_t                data_mem [NUM_LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with zero-wait
// read hits. Define DATA_CACHE_STATS_EN to add hit_count/miss_count outputs.
module data_cache
  import mips_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [31:0]  core_addr,
  input  logic         core_re,
  input  logic         core_we,
  input  word_t        core_wdata,
  output word_t        core_rdata,
  output logic         stall,
  data_cache_if.master mem
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int TAG_W = 30 - IDX_W;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   line_idx;
  logic [TAG_W-1:0]   line_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  word_t              rd_data;
  logic               hit;
  logic               wr_en;
  word_t              wr_data;
  logic               addr_lsb_unused;

  assign line_idx        = core_addr[2 +: IDX_W];
  assign line_tag        = core_addr[31 -: TAG_W];
  assign addr_lsb_unused = ^core_addr[1:0];

  cache_tag_ram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_tag_ram (
    .clk      (clk),
    .rst_b    (rst_b),
    .rd_idx   (line_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (line_idx),
    .wr_tag   (line_tag),
    .wr_data  (wr_data)
  );

  assign hit = rd_valid && (rd_tag == line_tag);

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    core_rdata = '0;
    wr_en      = 1'b0;
    wr_data    = core_wdata;
    case (state_q)
      IDLE: begin
        if (core_we) begin
          stall   = 1'b1;
          state_d = WRITE;
        end else if (core_re) begin
          if (hit) begin
            core_rdata = rd_data;
          end else begin
            stall   = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (mem.mem_ack) begin
          wr_en      = 1'b1;
          wr_data    = mem.mem_rdata;
          core_rdata = mem.mem_rdata;
          state_d    = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      WRITE: begin
        // No write-allocate: a store only refreshes a line it already owns.
        if (mem.mem_ack) begin
          wr_en   = hit;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_b) begin
      stall      = 1'b0;
      wr_en      = 1'b0;
      core_rdata = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Core holds its inputs while stalled, so the bus can be driven from them.
  assign mem.mem_req   = (state_q != IDLE);
  assign mem.mem_we    = (state_q == WRITE);
  assign mem.mem_addr  = {core_addr[31:2], 2'b00};
  assign mem.mem_wdata = core_wdata;

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] hit_count_d;
  logic [31:0] miss_count_q;
  logic [31:0] miss_count_d;
  logic        idle_read;

  assign idle_read = (state_q == IDLE) && core_re && !core_we;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (idle_read) begin
      if (hit) begin
        hit_count_d = hit_count_q + 32'd1;
      end else begin
        miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboarded bench for data_cache: directed scenarios then random loads and
// stores, checked against a line-valid/tag reference model and a word memory.
module tb_data_cache;
  import mips_pkg::*;

  localparam int NUM_LINES = 64;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] core_addr;
  logic        core_re;
  logic        core_we;
  word_t       core_wdata;
  word_t       core_rdata;
  logic        stall;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  data_cache_if mem_bus ();

  data_cache #(.NUM_LINES(NUM_LINES)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .core_addr  (core_addr),
    .core_re    (core_re),
    .core_we    (core_we),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .stall      (stall),
    .mem        (mem_bus)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    bit          exp_mem;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          force_lat = -1;
  bit          hold_ack = 1'b0;

  // Reference model: what memory holds, and which block each line caches.
  bit          ref_vld [NUM_LINES];
  int          ref_tag [NUM_LINES];
  logic [31:0] ref_mem [int];
  logic [31:0] bk_mem  [int];

  function automatic logic [31:0] init_word(int wa);
    return 32'hC0DE_0000 ^ (wa * 32'h0000_9E37);
  endfunction

  function automatic logic [31:0] ref_rd(int wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic clear_ref();
    foreach (ref_vld[i]) ref_vld[i] = 1'b0;
  endtask

  task automatic do_op(bit re, bit we, logic [31:0] addr, logic [31:0] wd);
    exp_t e;
    int   wa   = int'(addr >> 2);
    int   line = wa % NUM_LINES;
    int   tg   = wa / NUM_LINES;
    bit   hit  = ref_vld[line] && (ref_tag[line] == tg);
    int   n    = 0;
    e.addr    = {addr[31:2], 2'b00};
    e.is_load = re && !we;
    if (we) begin
      e.exp_mem   = 1'b1;
      ref_mem[wa] = wd;
      e.data      = wd;
    end else begin
      e.exp_mem     = !hit;
      e.data        = ref_rd(wa);
      ref_vld[line] = 1'b1;
      ref_tag[line] = tg;
    end
    sb_q.push_back(e);
    core_addr  = addr;
    core_re    = re;
    core_we    = we;
    core_wdata = wd;
    @(negedge clk);
    check("first_cycle_stall", {31'd0, stall}, {31'd0, e.exp_mem});
    while (stall && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (stall) begin
      checks++;
      errors++;
      $display("FAIL op_timeout actual=stall_held required=completion addr=%h", addr);
      finish_run();
    end
    @(posedge clk);
    #1;
    core_re = 1'b0;
    core_we = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a core access completes.
  initial begin : monitor
    bit          saw_mem = 1'b0;
    logic [31:0] m_addr  = '0;
    logic        m_we    = 1'b0;
    logic [31:0] m_wdata = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_b !== 1'b0) begin
        saw_mem = 1'b0;
      end else begin
        if (mem_bus.mem_req) begin
          saw_mem = 1'b1;
          m_addr  = mem_bus.mem_addr;
          m_we    = mem_bus.mem_we;
          m_wdata = mem_bus.mem_wdata;
        end
        if ((core_re || core_we) && !stall) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion actual=done required=none addr=%h", core_addr);
          end else begin
            e = sb_q.pop_front();
            check("mem_access", {31'd0, saw_mem}, {31'd0, e.exp_mem});
            if (e.exp_mem && saw_mem) begin
              check("mem_addr", m_addr, e.addr);
              check("mem_we", {31'd0, m_we}, {31'd0, !e.is_load});
              if (!e.is_load) check("mem_wdata", m_wdata, e.data);
            end
            if (e.is_load) check("load_data", core_rdata, e.data);
            else           check("store_rdata_zero", core_rdata, 32'd0);
            $display("txn %s addr=%h data=%h mem=%0d", e.is_load ? "LD" : "ST",
                     e.addr, e.is_load ? core_rdata : e.data, saw_mem);
          end
          saw_mem = 1'b0;
        end else begin
          check("idle_rdata_zero", core_rdata, 32'd0);
        end
      end
    end
  end

  // Backing memory with random latency; stray acks while idle must be ignored.
  initial begin : responder
    int wait_cnt = -1;
    int wa;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = '0;
      if (!mem_bus.mem_req || rst_b) begin
        wait_cnt = -1;
        if (!rst_b && !hold_ack && $urandom_range(0, 7) == 0) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = $urandom;
        end
      end else if (!hold_ack) begin
        if (wait_cnt < 0) wait_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        if (wait_cnt == 0) begin
          wa = int'(mem_bus.mem_addr >> 2);
          mem_bus.mem_ack = 1'b1;
          if (mem_bus.mem_we) bk_mem[wa] = mem_bus.mem_wdata;
          else mem_bus.mem_rdata = bk_mem.exists(wa) ? bk_mem[wa] : init_word(wa);
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    finish_run();
  end

  initial begin : stimulus
    logic [31:0] a;
    int          k;
    rst_b      = 1'b1;
    core_addr  = '0;
    core_re    = 1'b0;
    core_we    = 1'b0;
    core_wdata = '0;
    clear_ref();
    bk_mem[64]  = 32'hDEADBEEF;
    ref_mem[64] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    check("reset_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
    check("reset_rdata", core_rdata, 32'd0);
    rst_b = 1'b0;
    @(posedge clk);
    #1;

    do_op(1'b1, 1'b0, 32'h100, 32'h0);            // cold miss, fill DEADBEEF
    do_op(1'b1, 1'b0, 32'h100, 32'h0);            // zero-wait hit
    force_lat = 3;
    do_op(1'b0, 1'b1, 32'h100, 32'h11223344);     // write-through hit
    force_lat = -1;
    do_op(1'b1, 1'b0, 32'h100, 32'h0);
    do_op(1'b1, 1'b0, 32'h100 + 4 * NUM_LINES, 32'h0);  // alias evicts
    do_op(1'b1, 1'b0, 32'h100, 32'h0);
    do_op(1'b1, 1'b1, 32'h100 + 4 * NUM_LINES, 32'hA5A5_5A5A); // both high: store

    // Reset in the middle of a fill, before any ack arrives.
    hold_ack  = 1'b1;
    core_addr = 32'h104;
    core_re   = 1'b1;
    @(negedge clk);
    check("midfill_stall_before", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    check("midfill_mem_req", {31'd0, mem_bus.mem_req}, 32'd1);
    #1;
    rst_b = 1'b1;
    #1;
    check("midfill_rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    check("midfill_rst_stall", {31'd0, stall}, 32'd0);
    check("midfill_rst_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
    core_re = 1'b0;
    clear_ref();
    @(posedge clk);
    #1;
    rst_b    = 1'b0;
    hold_ack = 1'b0;
    do_op(1'b1, 1'b0, 32'h100, 32'h0);            // valid bits gone: misses

    for (int i = 0; i < 300; i++) begin
      a = ((($urandom_range(0, 3) * NUM_LINES) + $urandom_range(0, 7)) << 2)
          | $urandom_range(0, 3);
      k = $urandom_range(0, 9);
      if (k < 6)      do_op(1'b1, 1'b0, a, 32'h0);
      else if (k < 9) do_op(1'b0, 1'b1, a, $urandom);
      else            do_op(1'b1, 1'b1, a, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    finish_run();
  end

endmodule
